// File: rtl/keccak_padder.sv
// SHA-3 multi-rate padder: forwards 64-bit message lanes to the Keccak core and
// appends domain byte, zero fill and the closing 0x80 up to the rate boundary.
module keccak_padder #(
    parameter int unsigned RATE_WORDS = 17,
    parameter logic [7:0]  DOMAIN     = 8'h06
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] in_data,
    input  logic [3:0]  in_bytes,
    input  logic        in_last,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] din,
    output logic        din_valid,
    input  logic        buffer_full,
    output logic        last_block,
    output logic        busy
);

    localparam int unsigned LANE_BYTES = 8;
    localparam int unsigned CNT_W      = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE_WORDS - 1);

    typedef enum logic {
        ST_PASS,
        ST_PAD
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [CNT_W-1:0]  lane_cnt;
    logic [CNT_W-1:0]  lane_cnt_d;
    logic              dom_pend;
    logic              dom_pend_d;
    logic [63:0]       din_d;
    logic              din_valid_d;
    logic              last_block_d;
    logic              adv;
    logic              at_last;
    logic [3:0]        n_bytes;
    logic [63:0]       last_lane;

    // Output stage can take a new lane when empty or draining this cycle.
    assign adv     = !din_valid || !buffer_full;
    assign at_last = (lane_cnt == CNT_LAST);
    assign busy    = (state != ST_PASS) || din_valid;

    // Final partial lane: keep valid bytes, insert DOMAIN right after them.
    always_comb begin
        n_bytes   = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
        last_lane = '0;
        for (int i = 0; i < int'(LANE_BYTES); i++) begin
            if (4'(i) < n_bytes) begin
                last_lane[8*i +: 8] = in_data[8*i +: 8];
            end else if (4'(i) == n_bytes) begin
                last_lane[8*i +: 8] = DOMAIN;
            end
        end
    end

    // Next-state and output-stage load logic.
    always_comb begin
        state_d      = state;
        lane_cnt_d   = lane_cnt;
        dom_pend_d   = dom_pend;
        din_d        = din;
        din_valid_d  = din_valid;
        last_block_d = last_block;
        in_ready     = 1'b0;

        if (adv) begin
            din_valid_d = 1'b0;
        end

        case (state)
            ST_PASS: begin
                in_ready = adv;
                if (adv && in_valid) begin
                    din_valid_d  = 1'b1;
                    last_block_d = 1'b0;
                    lane_cnt_d   = at_last ? '0 : lane_cnt + CNT_W'(1);
                    if (!in_last) begin
                        din_d = in_data;
                    end else if (n_bytes == 4'd8) begin
                        // Full last lane: domain byte goes into the next lane.
                        din_d      = in_data;
                        state_d    = ST_PAD;
                        dom_pend_d = 1'b1;
                    end else begin
                        din_d = last_lane;
                        if (at_last) begin
                            din_d[63:56] = last_lane[63:56] | 8'h80;
                            last_block_d = 1'b1;
                        end else begin
                            state_d    = ST_PAD;
                            dom_pend_d = 1'b0;
                        end
                    end
                end
            end
            ST_PAD: begin
                if (adv) begin
                    din_d       = '0;
                    din_d[7:0]  = dom_pend ? DOMAIN : 8'h00;
                    dom_pend_d  = 1'b0;
                    din_valid_d = 1'b1;
                    if (at_last) begin
                        din_d[63:56] = 8'h80;
                        last_block_d = 1'b1;
                        state_d      = ST_PASS;
                        lane_cnt_d   = '0;
                    end else begin
                        last_block_d = 1'b0;
                        lane_cnt_d   = lane_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_PASS;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_PASS;
        end else begin
            state <= state_d;
        end
    end

    // Lane counter, pending-domain flag and registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt   <= '0;
            dom_pend   <= 1'b0;
            din        <= '0;
            din_valid  <= 1'b0;
            last_block <= 1'b0;
        end else begin
            lane_cnt   <= lane_cnt_d;
            dom_pend   <= dom_pend_d;
            din        <= din_d;
            din_valid  <= din_valid_d;
            last_block <= last_block_d;
        end
    end

endmodule

// File: tb/tb_keccak_padder.sv
// Directed bench for keccak_padder (RATE_WORDS=17, DOMAIN=06): single-lane
// vector table plus multi-lane, backpressure and reset sequences.
module tb_keccak_padder;

    localparam int unsigned RW = 17;
    localparam logic [63:0] CLOSE = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data;
    logic [3:0]  in_bytes;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] din;
    logic        din_valid;
    logic        buffer_full;
    logic        last_block;
    logic        busy;

    always #5 clk = ~clk;

    keccak_padder #(.RATE_WORDS(RW), .DOMAIN(8'h06)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_bytes   (in_bytes),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .din        (din),
        .din_valid  (din_valid),
        .buffer_full(buffer_full),
        .last_block (last_block),
        .busy       (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int ir_bad = 0;

    logic [63:0] oq[$];
    logic        ol[$];

    // Record every output transfer; in_ready must be low while pad lanes 1..15 are out.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && din_valid && !buffer_full) begin
            if (oq.size() >= 1 && oq.size() <= 15 && in_ready) ir_bad++;
            oq.push_back(din);
            ol.push_back(last_block);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic timeout_fail(input string nm);
        n_chk++;
        $display("FAIL %s: timeout", nm);
    endtask

    function automatic logic [63:0] lane(input int i);
        return (i < oq.size()) ? oq[i] : 64'bx;
    endfunction

    function automatic logic [63:0] lb_mask();
        logic [63:0] m = '0;
        for (int i = 0; i < ol.size() && i < 64; i++) m[i] = ol[i];
        return m;
    endfunction

    function automatic logic [63:0] zero_or(input int a, input int b);
        logic [63:0] r = '0;
        for (int i = a; i <= b; i++) r |= lane(i);
        return r;
    endfunction

    task automatic clear_out();
        oq.delete();
        ol.delete();
        ir_bad = 0;
    endtask

    task automatic put(input logic [63:0] d, input logic [3:0] nb, input logic last);
        int t = 0;
        @(negedge clk);
        in_data = d; in_bytes = nb; in_last = last; in_valid = 1'b1;
        #1;
        while (!in_ready && t < 200) begin
            @(negedge clk); #1; t++;
        end
        if (!in_ready) timeout_fail("put");
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int t = 0;
        @(negedge clk);
        while (busy && t < 500) begin
            @(negedge clk); t++;
        end
        if (busy) timeout_fail(nm);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_size(input int n, input string nm);
        int t = 0;
        while (oq.size() < n && t < 300) begin
            @(negedge clk); t++;
        end
        if (oq.size() < n) timeout_fail(nm);
    endtask

    task automatic stall5(input string nm);
        logic [63:0] d;
        logic        v;
        @(posedge clk); #2;
        buffer_full = 1'b1;
        d = din; v = din_valid;
        chk({nm, "_valid"}, 64'(v), 64'd1);
        repeat (5) begin
            @(negedge clk);
            chk({nm, "_din"}, din, d);
            chk({nm, "_dv"}, 64'(din_valid), 64'd1);
            chk({nm, "_rdy"}, 64'(in_ready), 64'd0);
        end
        @(posedge clk); #2;
        buffer_full = 1'b0;
    endtask

    // One-block message check: lane0/lane1 given, lanes 2..15 zero, lane16 closes.
    task automatic check_single(input string nm, input logic [63:0] e0, input logic [63:0] e1);
        chk({nm, "_count"}, 64'(oq.size()), 64'(RW));
        chk({nm, "_lane0"}, lane(0), e0);
        chk({nm, "_lane1"}, lane(1), e1);
        chk({nm, "_zeros"}, zero_or(2, 15), 64'd0);
        chk({nm, "_lane16"}, lane(16), CLOSE);
        chk({nm, "_lastblk"}, lb_mask(), 64'h1_0000);
    endtask

    typedef struct {
        logic [63:0] data;
        logic [3:0]  nb;
        logic [63:0] exp0;
        logic [63:0] exp1;
    } vec_t;

    vec_t        tv[7];
    logic [63:0] exp5[RW];

    initial begin
        tv[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'd0,  64'h0000_0000_0000_0006, 64'h0};
        tv[1] = '{64'h0000_0000_0063_6261, 4'd3,  64'h0000_0000_0663_6261, 64'h0};
        tv[2] = '{64'hAABB_CCDD_EEFF_0011, 4'd1,  64'h0000_0000_0000_0611, 64'h0};
        tv[3] = '{64'h1122_3344_5566_7788, 4'd7,  64'h0622_3344_5566_7788, 64'h0};
        tv[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'd5,  64'h0000_06FF_FFFF_FFFF, 64'h0};
        tv[5] = '{64'h1122_3344_5566_7788, 4'd8,  64'h1122_3344_5566_7788, 64'h6};
        tv[6] = '{64'h0102_0304_0506_0708, 4'd12, 64'h0102_0304_0506_0708, 64'h6};

        rst_n = 1'b0; in_data = '0; in_bytes = '0; in_last = 1'b0;
        in_valid = 1'b0; buffer_full = 1'b0;
        #1;
        chk("rst_din", din, 64'd0);
        chk("rst_dv", 64'(din_valid), 64'd0);
        chk("rst_lb", 64'(last_block), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rdy", 64'(in_ready), 64'd1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Single-lane messages, including empty and "abc".
        for (int v = 0; v < 7; v++) begin
            clear_out();
            put(tv[v].data, tv[v].nb, 1'b1);
            wait_idle($sformatf("idle%0d", v));
            check_single($sformatf("vec%0d", v), tv[v].exp0, tv[v].exp1);
            chk($sformatf("vec%0d_ready", v), 64'(ir_bad), 64'd0);
        end

        // Seven valid bytes on the boundary lane merge DOMAIN and 0x80.
        clear_out();
        for (int i = 0; i < 16; i++) put(64'h0123_4567_89AB_CDEF ^ 64'(i), 4'd8, 1'b0);
        put(64'h1122_3344_5566_7788, 4'd7, 1'b1);
        wait_idle("idle_merge");
        chk("merge_count", 64'(oq.size()), 64'(RW));
        for (int i = 0; i < 16; i++)
            chk($sformatf("merge_lane%0d", i), lane(i), 64'h0123_4567_89AB_CDEF ^ 64'(i));
        chk("merge_lane16", lane(16), 64'h8622_3344_5566_7788);
        chk("merge_lastblk", lb_mask(), 64'h1_0000);
        chk("merge_cnt", 64'(dut.lane_cnt), 64'd0);

        // Full last lane on the boundary forces a whole padding block.
        clear_out();
        for (int i = 0; i < 17; i++)
            put(64'hFEDC_BA98_7654_3210 + 64'(i), 4'd8, i == 16);
        wait_idle("idle_extra");
        chk("extra_count", 64'(oq.size()), 64'd34);
        for (int i = 0; i < 17; i++)
            chk($sformatf("extra_lane%0d", i), lane(i), 64'hFEDC_BA98_7654_3210 + 64'(i));
        chk("extra_lane17", lane(17), 64'h6);
        chk("extra_zeros", zero_or(18, 32), 64'd0);
        chk("extra_lane33", lane(33), CLOSE);
        chk("extra_lastblk", lb_mask(), 64'h2_0000_0000);

        // Backpressure mid-message and mid-pad.
        clear_out();
        for (int i = 0; i < int'(RW); i++) exp5[i] = '0;
        exp5[0] = 64'h1111_1111_1111_1111;
        exp5[1] = 64'h2222_2222_2222_2222;
        exp5[2] = 64'h3333_3333_3333_3333;
        exp5[3] = 64'h0000_0000_0006_ABCD;
        exp5[16] = CLOSE;
        fork
            begin
                put(exp5[0], 4'd8, 1'b0);
                put(exp5[1], 4'd8, 1'b0);
                put(exp5[2], 4'd8, 1'b0);
                put(64'hFFFF_FFFF_FFFF_ABCD, 4'd2, 1'b1);
            end
            begin
                wait_size(2, "bp_w1");
                stall5("bp_msg");
                wait_size(8, "bp_w2");
                stall5("bp_pad");
            end
        join
        wait_idle("idle_bp");
        chk("bp_count", 64'(oq.size()), 64'(RW));
        for (int i = 0; i < int'(RW); i++) chk($sformatf("bp_lane%0d", i), lane(i), exp5[i]);
        chk("bp_lastblk", lb_mask(), 64'h1_0000);

        // Reset during padding, then a clean "abc".
        clear_out();
        put(64'h0, 4'd0, 1'b1);
        wait_size(5, "rp_w");
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rp_din", din, 64'd0);
        chk("rp_dv", 64'(din_valid), 64'd0);
        chk("rp_lb", 64'(last_block), 64'd0);
        chk("rp_busy", 64'(busy), 64'd0);
        chk("rp_rdy", 64'(in_ready), 64'd1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        clear_out();
        put(64'h0000_0000_0063_6261, 4'd3, 1'b1);
        wait_idle("idle_rp");
        check_single("rp_abc", 64'h0000_0000_0663_6261, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
